uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_rx_core.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx_core.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with a 2-flop input synchronizer,
// configurable frame format (data width, optional parity, 1 or 2 stop bits),
// a ready/valid output holding register and overrun detection.
// A stop bit sampled low delivers a frame with frame_err set and parks the
// receiver in BREAK until the line returns high.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun_err,
    output logic                  busy
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        DATA_LAST = 3'(DATA_WIDTH - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic              ODD_BIT   = (PARITY_ODD != 0);
    localparam logic              HAS_PAR   = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_e;

    state_e                  state_q;
    logic [1:0]              sync_q;
    logic [CNT_W-1:0]        baud_cnt_q;
    logic [2:0]              bit_cnt_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic                    par_acc_q;
    logic                    perr_q;
    logic                    ferr_acc_q;
    logic [DATA_WIDTH-1:0]   rx_data_q;
    logic                    rx_valid_q;
    logic                    parity_err_q;
    logic                    frame_err_q;
    logic                    overrun_q;

    logic                    rx_s;
    logic                    stop_bad;
    logic                    handshake;

    assign rx_s      = sync_q[1];
    // Frame-error result including the stop bit being sampled right now.
    assign stop_bad  = ferr_acc_q | ~rx_s;
    assign handshake = rx_valid_q & rx_ready;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            // NOTE: non-blocking assignment keeps both flops sampling the
            // pre-edge values, so the chain really is two stages deep.
            sync_q <= {sync_q[0], rx};
        end
    end

    // Receive FSM, baud/bit counters and the registered output holding stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            baud_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_acc_q    <= 1'b0;
            perr_q       <= 1'b0;
            ferr_acc_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);

            // Consumer handshake drops the held frame; a load below overrides.
            if (handshake) begin
                rx_valid_q <= 1'b0;
                overrun_q  <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    baud_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                    if (!rx_s) begin
                        state_q <= START;
                    end
                end

                START: begin
                    if (baud_cnt_q == HALF_LAST) begin
                        baud_cnt_q <= '0;
                        if (rx_s) begin
                            // Start bit did not survive to mid-bit: a glitch.
                            state_q <= IDLE;
                        end else begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                            par_acc_q <= 1'b0;
                        end
                    end
                end

                DATA: begin
                    if (baud_cnt_q == FULL_LAST) begin
                        baud_cnt_q <= '0;
                        shift_q    <= {rx_s, shift_q[DATA_WIDTH-1:1]};
                        par_acc_q  <= par_acc_q ^ rx_s;
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_q  <= '0;
                            perr_q     <= 1'b0;
                            ferr_acc_q <= 1'b0;
                            state_q    <= HAS_PAR ? PARITY : STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                end

                PARITY: begin
                    if (baud_cnt_q == FULL_LAST) begin
                        baud_cnt_q <= '0;
                        perr_q     <= ((par_acc_q ^ rx_s) != ODD_BIT);
                        state_q    <= STOP;
                    end
                end

                STOP: begin
                    if (baud_cnt_q == FULL_LAST) begin
                        baud_cnt_q <= '0;
                        if (bit_cnt_q == STOP_LAST) begin
                            bit_cnt_q    <= '0;
                            rx_data_q    <= shift_q;
                            parity_err_q <= perr_q;
                            frame_err_q  <= stop_bad;
                            rx_valid_q   <= 1'b1;
                            if (rx_valid_q && !rx_ready) begin
                                overrun_q <= 1'b1;
                            end
                            state_q <= stop_bad ? BREAK : IDLE;
                        end else begin
                            ferr_acc_q <= stop_bad;
                            bit_cnt_q  <= bit_cnt_q + 3'd1;
                        end
                    end
                end

                BREAK: begin
                    baud_cnt_q <= '0;
                    if (rx_s) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at default parameters (16 clocks/bit,
// 8 data bits, even parity, 1 stop bit). Table-driven frames plus
// hand-written sequences for glitch, break, overrun and mid-frame reset.
module tb_uart_rx_core;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rise_cnt = 0;
    int rise_cyc = 0;
    logic valid_d = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       pbit;
        logic       sbit;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs [7];

    uart_rx_core dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: value N during the period that follows the N-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Count rising edges of rx_valid and remember when the latest one happened.
    always @(negedge clk) begin
        if (rx_valid && !valid_d) begin
            rise_cnt = rise_cnt + 1;
            rise_cyc = cyc;
        end
        valid_d = rx_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one full frame; each bit lasts CPB clocks. Line level after the
    // stop bit is left at end_level.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit,
                              input logic end_level);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(CPB);
        end
        rx = pbit;
        tick(CPB);
        rx = sbit;
        tick(CPB);
        rx = end_level;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!rx_valid && n < 400) begin
            tick(1);
            n++;
        end
        check(name, {31'd0, rx_valid}, 32'd1);
    endtask

    task automatic accept();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        int start;
        int base;
        logic [7:0] d;

        vecs[0] = '{data: 8'hA5, pbit: 1'b0, sbit: 1'b1, exp_data: 8'hA5, exp_perr: 1'b0, exp_ferr: 1'b0};
        vecs[1] = '{data: 8'hA5, pbit: 1'b1, sbit: 1'b1, exp_data: 8'hA5, exp_perr: 1'b1, exp_ferr: 1'b0};
        vecs[2] = '{data: 8'h00, pbit: 1'b0, sbit: 1'b1, exp_data: 8'h00, exp_perr: 1'b0, exp_ferr: 1'b0};
        vecs[3] = '{data: 8'hFF, pbit: 1'b0, sbit: 1'b1, exp_data: 8'hFF, exp_perr: 1'b0, exp_ferr: 1'b0};
        vecs[4] = '{data: 8'h01, pbit: 1'b1, sbit: 1'b1, exp_data: 8'h01, exp_perr: 1'b0, exp_ferr: 1'b0};
        vecs[5] = '{data: 8'h80, pbit: 1'b0, sbit: 1'b1, exp_data: 8'h80, exp_perr: 1'b1, exp_ferr: 1'b0};
        vecs[6] = '{data: 8'hC3, pbit: 1'b0, sbit: 1'b0, exp_data: 8'hC3, exp_perr: 1'b0, exp_ferr: 1'b1};

        rst      = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b0;
        tick(3);
        check("reset rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset rx_data", {24'd0, rx_data}, 32'd0);
        check("reset parity_err", {31'd0, parity_err}, 32'd0);
        check("reset frame_err", {31'd0, frame_err}, 32'd0);
        check("reset overrun_err", {31'd0, overrun_err}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        tick(4);

        // Table-driven single frames, each accepted before the next.
        for (int i = 0; i < 7; i++) begin
            base  = rise_cnt;
            start = cyc;
            send_frame(vecs[i].data, vecs[i].pbit, vecs[i].sbit, 1'b1);
            wait_valid($sformatf("vec%0d valid", i));
            check($sformatf("vec%0d rx_data", i), {24'd0, rx_data}, {24'd0, vecs[i].exp_data});
            check($sformatf("vec%0d parity_err", i), {31'd0, parity_err}, {31'd0, vecs[i].exp_perr});
            check($sformatf("vec%0d frame_err", i), {31'd0, frame_err}, {31'd0, vecs[i].exp_ferr});
            check($sformatf("vec%0d one frame", i), rise_cnt - base, 32'd1);
            // Line low at start+0 reaches the FSM two clocks later (T0 = start+2);
            // rx_valid rises at T0+169.
            if (i == 0) begin
                check("latency T0+169", rise_cyc - start, 32'd171);
            end
            accept();
            check($sformatf("vec%0d valid drop", i), {31'd0, rx_valid}, 32'd0);
            tick(2 * CPB);
        end

        // Glitch reject: line low for 4 clocks only.
        base  = rise_cnt;
        start = cyc;
        rx    = 1'b0;
        tick(4);
        rx    = 1'b1;
        check("glitch busy T0+2", {31'd0, busy}, 32'd1);
        tick(5);
        check("glitch busy T0+7", {31'd0, busy}, 32'd1);
        tick(2);
        check("glitch idle T0+9", {31'd0, busy}, 32'd0);
        tick(3 * CPB);
        check("glitch no frame", rise_cnt - base, 32'd0);

        // Break: stop bit 0, line held low 30 bit times, then 0x3C clean.
        base = rise_cnt;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        wait_valid("break frame valid");
        check("break frame_err", {31'd0, frame_err}, 32'd1);
        check("break rx_data", {24'd0, rx_data}, 32'h55);
        accept();
        tick(30 * CPB);
        check("break busy while low", {31'd0, busy}, 32'd1);
        check("break no extra frames", rise_cnt - base, 32'd1);
        rx = 1'b1;
        tick(2 * CPB);
        check("break released idle", {31'd0, busy}, 32'd0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
        wait_valid("after break valid");
        check("after break rx_data", {24'd0, rx_data}, 32'h3C);
        check("after break frame_err", {31'd0, frame_err}, 32'd0);
        check("after break parity_err", {31'd0, parity_err}, 32'd0);
        accept();
        tick(2 * CPB);

        // Overrun: two back-to-back frames with no consumer.
        send_frame(8'h11, 1'b0, 1'b1, 1'b1);
        check("ovr first valid", {31'd0, rx_valid}, 32'd1);
        check("ovr first no overrun", {31'd0, overrun_err}, 32'd0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1);
        check("ovr rx_data", {24'd0, rx_data}, 32'h22);
        check("ovr overrun_err", {31'd0, overrun_err}, 32'd1);
        check("ovr still valid", {31'd0, rx_valid}, 32'd1);
        accept();
        check("ovr valid cleared", {31'd0, rx_valid}, 32'd0);
        check("ovr overrun cleared", {31'd0, overrun_err}, 32'd0);
        tick(2 * CPB);

        // Reset in the middle of data bit 4 of 0x5A, then a clean 0x5A.
        d  = 8'h5A;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            tick(CPB);
        end
        rx  = d[4];
        rst = 1'b0;
        #2;
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst rx_valid", {31'd0, rx_valid}, 32'd0);
        check("midrst rx_data", {24'd0, rx_data}, 32'd0);
        check("midrst flags", {29'd0, parity_err, frame_err, overrun_err}, 32'd0);
        tick(2);
        rx  = 1'b1;
        rst = 1'b1;
        base = rise_cnt;
        tick(4 * CPB);
        check("midrst no spurious frame", rise_cnt - base, 32'd0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        wait_valid("midrst frame valid");
        check("midrst rx_data new", {24'd0, rx_data}, 32'h5A);
        check("midrst exactly one", rise_cnt - base, 32'd1);
        accept();
        tick(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
